// File: rtl/kmeans_pkg.sv
// kmeans_pkg: shared widths, latencies and FSM state encoding for the k-means control and datapath blocks.
package kmeans_pkg;
    localparam int addrWidth   = 8;
    localparam int dataWidth   = 16;
    localparam int count_width = addrWidth + 1;
    localparam int iter_width  = 8;
    localparam int RD_LAT      = 1;
    localparam int PIPE_DEPTH  = 2;
    localparam int VLD_LAT     = RD_LAT + PIPE_DEPTH;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;
    localparam logic [2:0] ST_CHECK  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_CLEAR  = ST_CLEAR,
        S_STREAM = ST_STREAM,
        S_DRAIN  = ST_DRAIN,
        S_UPDATE = ST_UPDATE,
        S_CHECK  = ST_CHECK,
        S_DONE   = ST_DONE
    } ctrl_state_e;
endpackage

// File: rtl/kmeans_valid_pipe.sv
// kmeans_valid_pipe: valid shift register tracking points through memory read and the pipe stages.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   flush_i     synchronous clear of every stage (wins over the shift)
//   in_i        valid entering stage 0
//   vsr_o       all stage valids; bit k is the input delayed by k+1 cycles
module kmeans_valid_pipe #(
    parameter int LEN = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush_i,
    input  logic           in_i,
    output logic [LEN-1:0] vsr_o
);
    logic [LEN-1:0] vsr_q, vsr_d;
    always_comb vsr_d = flush_i ? '0 : (vsr_q << 1) | LEN'(in_i);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) vsr_q <= '0;
        else        vsr_q <= vsr_d;
    assign vsr_o = vsr_q;
endmodule

// File: rtl/kmeans_iter_ctrl.sv
// kmeans_iter_ctrl: iteration sequencer for the k-means datapath (read -> distance -> classify -> accumulate -> update).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i, abort_i  run start pulse (IDLE only), synchronous abort (wins over start)
//   last_addr_i       final point address, max_iter_i iteration limit (0 acts as 1); both sampled on start
//   mem_rd_en_o, mem_addr_o             point-memory read strobe and address
//   pipe1_valid_o, accum_en_o           valid at pipe1 input and at the pipe3 accumulate point
//   accum_clear_o                       clears pipe3 accumulators at the start of every iteration
//   update_start_o, update_done_i, converged_i  handshake with the centroid update block
//   busy_o, done_o                      run in progress, end-of-run pulse
//   iter_count_o, hit_limit_o           completed iterations, run ended on the iteration limit
module kmeans_iter_ctrl
    import kmeans_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [addrWidth-1:0]  last_addr_i,
    input  logic [iter_width-1:0] max_iter_i,
    output logic                  mem_rd_en_o,
    output logic [addrWidth-1:0]  mem_addr_o,
    output logic                  pipe1_valid_o,
    output logic                  accum_clear_o,
    output logic                  accum_en_o,
    output logic                  update_start_o,
    input  logic                  update_done_i,
    input  logic                  converged_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [iter_width-1:0] iter_count_o,
    output logic                  hit_limit_o
);
    ctrl_state_e           state_q, state_d;
    logic [addrWidth-1:0]  addr_q, addr_d, last_q, last_d;
    logic [iter_width-1:0] max_q, max_d, iter_q, iter_d;
    logic                  hit_q, hit_d, conv_q, conv_d, ufirst_q, ufirst_d;
    logic [VLD_LAT-1:0]    vsr;
    // one extra bit so the limit compare cannot wrap at the top of the counter range
    logic [iter_width:0]   iter_inc;
    assign iter_inc = {1'b0, iter_q} + 1'b1;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        max_d   = max_q;
        iter_d  = iter_q;
        hit_d   = hit_q;
        conv_d  = conv_q;
        if (abort_i) state_d = S_IDLE;
        else case (state_q)
            S_IDLE: if (start_i) begin
                last_d  = last_addr_i;
                max_d   = (max_iter_i == '0) ? iter_width'(1) : max_iter_i;
                iter_d  = '0;
                hit_d   = 1'b0;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                addr_d  = '0;
                state_d = S_STREAM;
            end
            S_STREAM: if (addr_q == last_q) state_d = S_DRAIN;
                      else                  addr_d  = addr_q + 1'b1;
            S_DRAIN: if (vsr == '0) state_d = S_UPDATE;
            S_UPDATE: if (update_done_i) begin
                conv_d  = converged_i;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                iter_d = iter_inc[iter_width-1:0];
                if (conv_q) begin
                    hit_d   = 1'b0;
                    state_d = S_DONE;
                end else if (iter_inc >= {1'b0, max_q}) begin
                    hit_d   = 1'b1;
                    state_d = S_DONE;
                end else state_d = S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase
        ufirst_d = (state_d == S_UPDATE) && (state_q != S_UPDATE);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            last_q   <= '0;
            max_q    <= '0;
            iter_q   <= '0;
            hit_q    <= 1'b0;
            conv_q   <= 1'b0;
            ufirst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            max_q    <= max_d;
            iter_q   <= iter_d;
            hit_q    <= hit_d;
            conv_q   <= conv_d;
            ufirst_q <= ufirst_d;
        end
    kmeans_valid_pipe #(.LEN(VLD_LAT)) u_vld (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (abort_i),
        .in_i    (mem_rd_en_o),
        .vsr_o   (vsr)
    );
    assign mem_rd_en_o    = state_q == S_STREAM;
    assign mem_addr_o     = addr_q;
    assign pipe1_valid_o  = vsr[RD_LAT-1];
    assign accum_en_o     = vsr[VLD_LAT-1];
    assign accum_clear_o  = state_q == S_CLEAR;
    assign update_start_o = ufirst_q;
    assign busy_o         = state_q != S_IDLE;
    assign done_o         = state_q == S_DONE;
    assign iter_count_o   = iter_q;
    assign hit_limit_o    = hit_q;
endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// tb_kmeans_iter_ctrl: directed and randomized runs of kmeans_iter_ctrl checked against a run-level reference model.
module tb_kmeans_iter_ctrl;
    import kmeans_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, abort_i = 1'b0;
    logic [addrWidth-1:0]  last_addr_i = '0;
    logic [iter_width-1:0] max_iter_i = '0;
    logic update_done_i = 1'b0, converged_i = 1'b0;
    logic mem_rd_en_o, pipe1_valid_o, accum_clear_o, accum_en_o, update_start_o, busy_o, done_o, hit_limit_o;
    logic [addrWidth-1:0]  mem_addr_o;
    logic [iter_width-1:0] iter_count_o;
    int checks = 0, errors = 0;
    int cyc = 0, n_rd = 0, n_acc = 0, n_runs = 0, n_us = 0, n_done = 0, n_clr = 0, lat_err = 0, p1_err = 0;
    bit prev_rd = 0, prev_acc = 0;
    int rdq[$];
    int addrs[$];

    kmeans_iter_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .last_addr_i(last_addr_i), .max_iter_i(max_iter_i),
        .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o), .pipe1_valid_o(pipe1_valid_o),
        .accum_clear_o(accum_clear_o), .accum_en_o(accum_en_o), .update_start_o(update_start_o),
        .update_done_i(update_done_i), .converged_i(converged_i),
        .busy_o(busy_o), .done_o(done_o), .iter_count_o(iter_count_o), .hit_limit_o(hit_limit_o)
    );

    always #5 clk = ~clk;

    // Observer: records reads, accumulate pulses and handshake events; each accumulate pulse
    // must match the oldest surviving read exactly VLD_LAT cycles earlier.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            rdq.delete();
            prev_rd  = 0;
            prev_acc = 0;
        end else begin
            if (pipe1_valid_o !== prev_rd) p1_err++;
            if (accum_en_o) begin
                n_acc++;
                if (!prev_acc) n_runs++;
                if (rdq.size() == 0) lat_err++;
                else if (cyc - rdq.pop_front() != VLD_LAT) lat_err++;
            end
            if (abort_i) rdq.delete();
            if (mem_rd_en_o) begin
                n_rd++;
                addrs.push_back(int'(mem_addr_o));
                if (!abort_i) rdq.push_back(cyc);
            end
            prev_rd  = mem_rd_en_o && !abort_i;
            prev_acc = accum_en_o;
            if (update_start_o) n_us++;
            if (done_o) n_done++;
            if (accum_clear_o) n_clr++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs_packed();
        return {mem_rd_en_o, pipe1_valid_o, accum_clear_o, accum_en_o, update_start_o,
                busy_o, done_o, hit_limit_o, 8'(mem_addr_o), 8'(iter_count_o)};
    endfunction

    // One full run; conv_at is the update round (1-based) that reports convergence, 0 = never.
    task automatic run(input int last, input int mi, input int conv_at, input bit inject);
        int eff, iters, hit, base, rd0, acc0, runs0, us0, done0, clr0, lat0, p10;
        int ups, dly, budget, bad, per;
        bit fin;
        eff = (mi == 0) ? 1 : mi;
        if (conv_at > 0 && conv_at <= eff) begin iters = conv_at; hit = 0; end
        else begin iters = eff; hit = 1; end
        per = last + 1;
        base = addrs.size(); rd0 = n_rd; acc0 = n_acc; runs0 = n_runs; us0 = n_us;
        done0 = n_done; clr0 = n_clr; lat0 = lat_err; p10 = p1_err;
        last_addr_i = addrWidth'(last);
        max_iter_i  = iter_width'(mi);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        last_addr_i = addrWidth'($urandom);
        max_iter_i  = iter_width'($urandom);
        chk("busy_after_start", busy_o, 1);
        ups = 0; dly = -1; fin = 0; bad = 0;
        budget = iters * (per + 20) + 20;
        for (int c = 0; c < budget && !fin; c++) begin
            update_done_i = 1'b0;
            converged_i   = 1'($urandom);
            start_i       = 1'b0;
            if (done_o) fin = 1;
            else begin
                if (update_start_o) begin ups++; dly = $urandom_range(0, 3); end
                if (dly == 0) begin update_done_i = 1'b1; converged_i = (ups == conv_at); end
                if (dly >= 0) dly--;
                if (inject && mem_rd_en_o && mem_addr_o == 1) begin
                    start_i = 1'b1; update_done_i = 1'b1; converged_i = 1'b1;
                end
                @(posedge clk); #1;
            end
        end
        update_done_i = 1'b0;
        start_i = 1'b0;
        chk("done_seen", fin, 1);
        chk("iter_count", iter_count_o, iters);
        chk("hit_limit", hit_limit_o, hit);
        @(posedge clk); #1;
        chk("done_one_cycle", done_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("iter_held", iter_count_o, iters);
        chk("n_reads", n_rd - rd0, iters * per);
        chk("n_accum", n_acc - acc0, iters * per);
        chk("accum_runs", n_runs - runs0, iters);
        chk("n_update_start", n_us - us0, iters);
        chk("n_clear", n_clr - clr0, iters);
        chk("n_done", n_done - done0, 1);
        chk("accum_latency", lat_err - lat0, 0);
        chk("pipe1_valid", p1_err - p10, 0);
        for (int i = 0; i < iters * per && base + i < addrs.size(); i++)
            if (addrs[base + i] != i % per) bad++;
        chk("addr_seq", bad, 0);
    endtask

    initial begin
        int acc0, done0, seen;
        #12;
        chk("reset_outputs", outs_packed(), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", busy_o, 0);
        run(3, 5, 1, 0);
        run(7, 3, 0, 0);
        run(0, 0, 0, 0);
        // abort on the third STREAM cycle
        last_addr_i = 8'd15; max_iter_i = 8'd3; start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (mem_rd_en_o && mem_addr_o == 2) seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk("abort_reached", seen, 1);
        abort_i = 1'b1;
        @(posedge clk); #1; abort_i = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_accum", accum_en_o, 0);
        chk("abort_rd", mem_rd_en_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_iter", iter_count_o, 0);
        acc0 = n_acc; done0 = n_done;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_accum", n_acc - acc0, 0);
        chk("abort_no_done", n_done - done0, 0);
        abort_i = 1'b1; start_i = 1'b1;
        @(posedge clk); #1; abort_i = 1'b0; start_i = 1'b0;
        chk("abort_beats_start", busy_o, 0);
        run(15, 2, 0, 0);
        // asynchronous reset during DRAIN
        last_addr_i = 8'd7; max_iter_i = 8'd2; start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 30 && seen < 2; c++) begin
            if (mem_rd_en_o) seen = 1;
            else if (seen == 1 && busy_o) seen = 2;
            if (seen < 2) begin @(posedge clk); #1; end
        end
        chk("drain_reached", seen, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs_packed(), 0);
        @(negedge clk); @(negedge clk);
        chk("reset_held_outputs", outs_packed(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_release_idle", busy_o, 0);
        run(3, 5, 1, 0);
        run(5, 2, 0, 1);
        run(255, 1, 0, 0);
        run(0, 1, 1, 0);
        for (int r = 0; r < 6; r++)
            run($urandom_range(0, 12), $urandom_range(0, 4), $urandom_range(0, 5), 1'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
